// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port integer register file with a self-clearing
// init sequence, optional write bypass and a sticky ecall halt detector.
module regfile_mp #(
    parameter int               XLEN     = 32,
    parameter int               NREGS    = 32,
    parameter int               NREAD    = 2,
    parameter int               BYPASS   = 1,
    parameter int               SP_IDX   = 2,
    parameter logic [XLEN-1:0]  SP_INIT  = 'h2ffc,
    parameter int               HALT_REG = 17,
    parameter logic [XLEN-1:0]  HALT_VAL = 10,
    localparam int              AW       = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREAD*AW-1:0]   rs_addr,
    output logic [NREAD*XLEN-1:0] rs_dout,
    input  logic [AW-1:0]         rd,
    input  logic [XLEN-1:0]       rd_din,
    input  logic                  write_enable,
    input  logic                  is_ecall,
    output logic                  ready,
    output logic                  is_halted
);

    typedef enum logic {INIT, RUN} state_t;

    state_t            state, state_nx;
    logic [AW-1:0]     icnt, icnt_nx;
    logic              halted_nx;
    logic [XLEN-1:0]   rf [NREGS];
    logic              run_wr;
    logic              arr_we;
    logic [AW-1:0]     arr_addr;
    logic [XLEN-1:0]   arr_data;
    logic [XLEN-1:0]   hv;

    assign ready  = (state == RUN);
    assign run_wr = (state == RUN) && write_enable
                    && (rd != '0) && !is_halted;

    assign hv = (BYPASS != 0 && run_wr && rd == AW'(HALT_REG))
                ? rd_din : rf[HALT_REG];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= INIT;
            icnt      <= '0;
            is_halted <= 1'b0;
        end else begin
            state     <= state_nx;
            icnt      <= icnt_nx;
            is_halted <= halted_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        icnt_nx   = icnt;
        halted_nx = is_halted;
        arr_we    = 1'b0;
        arr_addr  = rd;
        arr_data  = rd_din;
        unique case (state)
            INIT: begin
                // Entry 0 is never stored: reads of x0 are forced to zero.
                arr_we   = (icnt != '0);
                arr_addr = icnt;
                arr_data = (icnt == AW'(SP_IDX)) ? SP_INIT : '0;
                icnt_nx  = icnt + AW'(1);
                if (icnt == AW'(NREGS - 1))
                    state_nx = RUN;
            end
            RUN: begin
                arr_we = run_wr;
                if (is_ecall && hv == HALT_VAL)
                    halted_nx = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (arr_we)
            rf[arr_addr] <= arr_data;
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;

        assign a = rs_addr[i*AW +: AW];

        always_comb begin
            d = rf[a];
            if (!ready || a == '0)
                d = '0;
            else if (BYPASS != 0 && run_wr && rd == a)
                d = rd_din;
        end

        assign rs_dout[i*XLEN +: XLEN] = d;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp, three instances
// (bypass, no bypass, 8x64 with three read ports) against a reference model.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // Per-instance stimulus: 0 = bypass, 1 = no bypass, 2 = wide
    logic        in_we    [3];
    int          in_rd    [3];
    logic [63:0] in_din   [3];
    logic        in_ecall [3];
    int          in_addr  [3][3];

    logic [9:0]   rs_addr_m;
    logic [4:0]   rd_m;
    logic [31:0]  din_m;
    logic [63:0]  dout_m, dout_n;
    logic [8:0]   rs_addr_w;
    logic [2:0]   rd_w;
    logic [63:0]  din_w;
    logic [191:0] dout_w;
    logic         rdy_m, rdy_n, rdy_w;
    logic         hlt_m, hlt_n, hlt_w;

    assign rs_addr_m = {in_addr[0][1][4:0], in_addr[0][0][4:0]};
    assign rd_m      = in_rd[0][4:0];
    assign din_m     = in_din[0][31:0];
    assign rs_addr_w = {in_addr[2][2][2:0], in_addr[2][1][2:0],
                        in_addr[2][0][2:0]};
    assign rd_w      = in_rd[2][2:0];
    assign din_w     = in_din[2];

    regfile_mp u_main (
        .clk(clk), .reset(reset), .rs_addr(rs_addr_m), .rs_dout(dout_m),
        .rd(rd_m), .rd_din(din_m), .write_enable(in_we[0]),
        .is_ecall(in_ecall[0]), .ready(rdy_m), .is_halted(hlt_m)
    );

    regfile_mp #(.BYPASS(0)) u_nb (
        .clk(clk), .reset(reset), .rs_addr(rs_addr_m), .rs_dout(dout_n),
        .rd(rd_m), .rd_din(din_m), .write_enable(in_we[1]),
        .is_ecall(in_ecall[1]), .ready(rdy_n), .is_halted(hlt_n)
    );

    regfile_mp #(.XLEN(64), .NREGS(8), .NREAD(3), .HALT_REG(5)) u_wide (
        .clk(clk), .reset(reset), .rs_addr(rs_addr_w), .rs_dout(dout_w),
        .rd(rd_w), .rd_din(din_w), .write_enable(in_we[2]),
        .is_ecall(in_ecall[2]), .ready(rdy_w), .is_halted(hlt_w)
    );

    // Reference model
    int          nregs [3] = '{32, 32, 8};
    bit          byp   [3] = '{1'b1, 1'b0, 1'b1};
    int          hreg  [3] = '{17, 17, 5};
    int          nport [3] = '{2, 2, 3};
    logic [63:0] mem   [3][32];
    bit          hlt   [3];
    int          edges;

    typedef struct packed {
        logic [2:0]       rdy;
        logic [2:0]       hlt;
        logic [8:0][63:0] dat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic bit qual(int k);
        return edges >= nregs[k] && in_we[k]
               && in_rd[k] != 0 && !hlt[k];
    endfunction

    function automatic logic [63:0] exp_rd(int k, int p);
        int a = in_addr[k][p];
        if (edges < nregs[k] || a == 0) return 64'd0;
        if (byp[k] && qual(k) && in_rd[k] == a) return in_din[k];
        return mem[k][a];
    endfunction

    task automatic push_exp();
        exp_t e;
        e = '0;
        for (int k = 0; k < 3; k++) begin
            e.rdy[k] = (edges >= nregs[k]);
            e.hlt[k] = hlt[k];
            for (int p = 0; p < nport[k]; p++)
                e.dat[k*3+p] = exp_rd(k, p);
        end
        sb.push_back(e);
    endtask

    task automatic model_edge();
        logic [63:0] hv;
        for (int k = 0; k < 3; k++) begin
            if (edges < nregs[k]) begin
                if (edges + 1 == nregs[k])
                    for (int i = 0; i < 32; i++)
                        mem[k][i] = (i == 2) ? 64'h2ffc : 64'd0;
            end else begin
                hv = (byp[k] && qual(k) && in_rd[k] == hreg[k])
                     ? in_din[k] : mem[k][hreg[k]];
                if (qual(k)) mem[k][in_rd[k]] = in_din[k];
                if (in_ecall[k] && hv == 64'd10) hlt[k] = 1'b1;
            end
        end
        if (edges < 1000) edges++;
    endtask

    task automatic rand_wide();
        in_we[2]    = 1'($urandom_range(0, 1));
        in_rd[2]    = $urandom_range(0, 7);
        in_din[2]   = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom}
                      : 64'($urandom_range(0, 15));
        in_ecall[2] = ($urandom_range(0, 15) == 0);
        for (int p = 0; p < 3; p++)
            in_addr[2][p] = ($urandom_range(0, 2) == 0) ? in_rd[2]
                            : $urandom_range(0, 7);
    endtask

    task automatic drive(bit we, int rd, logic [31:0] din, bit ec,
                         int a0, int a1);
        for (int k = 0; k < 2; k++) begin
            in_we[k]      = we;
            in_rd[k]      = rd;
            in_din[k]     = {32'd0, din};
            in_ecall[k]   = ec;
            in_addr[k][0] = a0;
            in_addr[k][1] = a1;
            in_addr[k][2] = 0;
        end
        rand_wide();
        push_exp();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic rand_drive();
        int rd = ($urandom_range(0, 3) == 0) ? 17 : $urandom_range(0, 31);
        logic [31:0] din = ($urandom_range(0, 2) == 0)
                           ? 32'($urandom_range(8, 11)) : $urandom;
        int a0 = ($urandom_range(0, 2) == 0) ? rd : $urandom_range(0, 31);
        int a1 = ($urandom_range(0, 2) == 0) ? 17 : $urandom_range(0, 31);
        drive(1'($urandom_range(0, 1)), rd, din,
              $urandom_range(0, 15) == 0, a0, a1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        edges = 0;
        for (int k = 0; k < 3; k++) hlt[k] = 1'b0;
        push_exp();
        @(negedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk(string nm, logic [63:0] got, logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, got, want,
                     $time);
        end
    endtask

    function automatic logic [63:0] act_rd(int k, int p);
        if (k == 0) return {32'd0, dout_m[p*32 +: 32]};
        if (k == 1) return {32'd0, dout_n[p*32 +: 32]};
        return dout_w[p*64 +: 64];
    endfunction

    // Monitor: one expectation per cycle, compared at the falling edge
    initial begin
        exp_t        e;
        logic [2:0]  ar, ah;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e  = sb.pop_front();
                ar = {rdy_w, rdy_n, rdy_m};
                ah = {hlt_w, hlt_n, hlt_m};
                for (int k = 0; k < 3; k++) begin
                    chk($sformatf("ready[%0d]", k),
                        64'(ar[k]), 64'(e.rdy[k]));
                    chk($sformatf("halted[%0d]", k),
                        64'(ah[k]), 64'(e.hlt[k]));
                    for (int p = 0; p < nport[k]; p++)
                        chk($sformatf("dout[%0d][%0d]", k, p),
                            act_rd(k, p), e.dat[k*3+p]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            in_we[k] = 1'b0; in_rd[k] = 0; in_din[k] = '0;
            in_ecall[k] = 1'b0; hlt[k] = 1'b0;
            for (int p = 0; p < 3; p++) in_addr[k][p] = 0;
        end
        edges = 0;
        @(posedge clk);
        #1;
        do_reset();
        repeat (31) drive(1'b1, 5, 32'h77, 1'b1, 2, 5);
        drive(1'b0, 0, 32'h0, 1'b0, 2, 5);
        drive(1'b1, 5, 32'hdeadbeef, 1'b0, 5, 5);
        drive(1'b0, 0, 32'h0, 1'b0, 5, 5);
        drive(1'b1, 0, 32'h1234, 1'b0, 0, 0);
        drive(1'b0, 0, 32'h0, 1'b0, 0, 5);
        drive(1'b1, 7, 32'h55, 1'b0, 7, 7);
        drive(1'b0, 0, 32'h0, 1'b0, 7, 0);
        drive(1'b1, 17, 32'h9, 1'b0, 17, 0);
        drive(1'b0, 0, 32'h0, 1'b1, 17, 5);
        drive(1'b1, 17, 32'd10, 1'b1, 17, 0);
        drive(1'b0, 0, 32'h0, 1'b1, 17, 0);
        drive(1'b1, 5, 32'h1, 1'b0, 5, 17);
        drive(1'b0, 0, 32'h0, 1'b0, 5, 17);
        do_reset();
        repeat (11) drive(1'b0, 0, 32'h0, 1'b0, 2, 0);
        do_reset();
        repeat (33) drive(1'b0, 0, 32'h0, 1'b0, 2, 3);
        for (int r = 0; r < 4; r++) begin
            do_reset();
            repeat (120) rand_drive();
        end
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
